// File: rtl/p_pkg.sv
// Widths and feeder state encoding shared by the message feeder and the Poly1305 tag engine.
// Pure declarations with no logic, latency or backpressure.
package p_pkg;

   localparam int P_BLK_W = 128;
   localparam int P_LEN_W = 65;
   localparam int P_WRD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SERVE,
      ST_DRAIN
   } feed_state_t;

   // Keeps the bytes of a final word that lie inside the message; len_mod==0 means a full word.
   function automatic logic [P_WRD_W-1:0] last_word_mask(input logic [1:0] len_mod);
      logic [P_WRD_W-1:0] m;
      case (len_mod)
         2'd1:    m = 32'h0000_00FF;
         2'd2:    m = 32'h0000_FFFF;
         2'd3:    m = 32'h00FF_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/p_blk_fifo.sv
// DEPTH x 128-bit synchronous block FIFO; a push is visible at head the next cycle.
// Writes while full and reads while empty are ignored; the caller stalls on full/empty.
module p_blk_fifo
   import p_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic [P_BLK_W-1:0] push_dat,
   input  logic               pop,
   output logic [P_BLK_W-1:0] head_dat,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]        wr_ptr;
   logic [AW:0]        rd_ptr;
   logic [P_BLK_W-1:0] mem [DEPTH];
   logic               do_push;
   logic               do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: head is only consumed once the pointers say it is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/p_msg_feed.sv
// Packs 32-bit LE words into 128-bit blocks for the Poly1305 engine; start/block pulse 1 cycle after pop.
// Upstream stalls via o_ready when the block FIFO is full; P_FEED_PROTO_CHK_EN builds the o_err checker.
module p_msg_feed
   import p_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LEN_W = P_LEN_W
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_msg_start,
   input  logic [LEN_W-1:0]   i_msg_len,
   input  logic               i_valid,
   input  logic [P_WRD_W-1:0] i_data,
   output logic               o_ready,
   input  logic               i_rqst_msg,
   input  logic               i_tag_done,
   output logic               o_start,
   output logic               o_en_msg,
   output logic [P_BLK_W-1:0] o_msg,
   output logic [LEN_W-1:0]   o_len_msg,
   output logic               o_busy,
   output logic               o_err
);

   feed_state_t        state, state_nxt;
   logic [LEN_W-1:0]   words_left;
   logic [LEN_W-1:0]   blk_left;
   logic [1:0]         word_idx;
   logic               pending;
   logic               zero_push;
   logic [P_BLK_W-1:0] asm_q;
   logic [P_BLK_W-1:0] asm_with;

   logic [LEN_W-1:0]   nwrd_in;
   logic [LEN_W-1:0]   nblk_lat;
   logic               accept;
   logic               last_wrd;
   logic               blk_done;
   logic [P_WRD_W-1:0] wrd_in;
   logic               rqst_take;

   logic               fifo_push;
   logic               fifo_pop;
   logic [P_BLK_W-1:0] fifo_push_dat;
   logic [P_BLK_W-1:0] fifo_head;
   logic               fifo_full;
   logic               fifo_empty;

   assign nwrd_in  = (i_msg_len >> 2) + LEN_W'(i_msg_len[1:0] != 2'b0);
   assign nblk_lat = (o_len_msg == '0) ? LEN_W'(1)
                   : (o_len_msg >> 4) + LEN_W'(o_len_msg[3:0] != 4'b0);

   assign last_wrd = (words_left == LEN_W'(1));
   assign blk_done = (word_idx == 2'd3) || last_wrd;
   assign o_ready  = o_busy && (words_left != '0) && !(fifo_full && blk_done);
   assign accept   = i_valid && o_ready;
   assign wrd_in   = i_data & (last_wrd ? last_word_mask(o_len_msg[1:0]) : '1);

   always_comb begin
      asm_with = asm_q;
      asm_with[{word_idx, 5'd0} +: P_WRD_W] = wrd_in;
   end

   // An empty message still owes the engine one all-zero block.
   assign fifo_push     = (accept && blk_done) || zero_push;
   assign fifo_push_dat = zero_push ? '0 : asm_with;

   assign rqst_take = i_rqst_msg && (state == ST_SERVE) && !pending && (blk_left != '0);

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE:  if (i_msg_start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (pending && !fifo_empty) fifo_pop = 1'b1;
            else if ((blk_left == '0) && !pending) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (i_tag_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state      <= ST_IDLE;
         words_left <= '0;
         blk_left   <= '0;
         word_idx   <= '0;
         pending    <= 1'b0;
         zero_push  <= 1'b0;
         asm_q      <= '0;
         o_start    <= 1'b0;
         o_en_msg   <= 1'b0;
         o_msg      <= '0;
         o_len_msg  <= '0;
         o_busy     <= 1'b0;
      end else begin
         state     <= state_nxt;
         o_start   <= 1'b0;
         o_en_msg  <= 1'b0;
         zero_push <= 1'b0;

         if ((state == ST_IDLE) && i_msg_start) begin
            o_len_msg  <= i_msg_len;
            o_busy     <= 1'b1;
            words_left <= nwrd_in;
            word_idx   <= '0;
            asm_q      <= '0;
            zero_push  <= (i_msg_len == '0);
         end else if (accept) begin
            words_left <= words_left - LEN_W'(1);
            word_idx   <= word_idx + 2'd1;
            asm_q      <= blk_done ? '0 : asm_with;
         end

         if (fifo_pop) begin
            o_msg <= fifo_head;
            if (state == ST_LOAD) begin
               o_start  <= 1'b1;
               blk_left <= nblk_lat - LEN_W'(1);
            end else begin
               o_en_msg <= 1'b1;
               blk_left <= blk_left - LEN_W'(1);
            end
         end

         if (fifo_pop)       pending <= 1'b0;
         else if (rqst_take) pending <= 1'b1;

         if ((state == ST_DRAIN) && i_tag_done) o_busy <= 1'b0;
      end
   end

`ifdef P_FEED_PROTO_CHK_EN
   logic rqst_bad;
   logic word_bad;

   assign rqst_bad = i_rqst_msg && ((state == ST_IDLE) || (state == ST_LOAD) ||
                                    pending || (blk_left == '0));
   assign word_bad = i_valid && o_busy && (words_left == '0);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)                   o_err <= 1'b0;
      else if (rqst_bad || word_bad) o_err <= 1'b1;
   end
`else
   assign o_err = 1'b0;
`endif

   p_blk_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (i_clk),
      .rst_n    (i_rstn),
      .push     (fifo_push),
      .push_dat (fifo_push_dat),
      .pop      (fifo_pop),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_p_msg_feed.sv
// Directed bench for p_msg_feed: a vector table of length/mask cases plus sequences for
// zero length, FIFO-full stall, late data and mid-message reset.
module tb_p_msg_feed;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         msg_start = 1'b0;
   logic [64:0]  msg_len = '0;
   logic         valid = 1'b0;
   logic [31:0]  data = '0;
   logic         ready;
   logic         rqst = 1'b0;
   logic         tag_done = 1'b0;
   logic         start;
   logic         en_msg;
   logic [127:0] msg;
   logic [64:0]  len_msg;
   logic         busy;
   logic         err;

   p_msg_feed #(.DEPTH(4), .LEN_W(65)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_msg_start(msg_start), .i_msg_len(msg_len),
      .i_valid(valid), .i_data(data), .o_ready(ready), .i_rqst_msg(rqst),
      .i_tag_done(tag_done), .o_start(start), .o_en_msg(en_msg), .o_msg(msg),
      .o_len_msg(len_msg), .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [64:0]  len;
      int           nwrd;
      logic [31:0]  fill;
      int           nblk;
      logic [127:0] first;
      logic [127:0] last;
   } vec_t;

   typedef struct {
      bit           is_start;
      logic [127:0] dat;
      int           cyc;
   } ev_t;

   vec_t        tbl[6];
   ev_t         ev_q[$];
   int          acc_q[$];
   int          rdy_cnt;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [31:0] wd[32];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start || en_msg) ev_q.push_back('{is_start: start, dat: msg, cyc: cyc});
      if (valid && ready) acc_q.push_back(cyc + 1);
      if (ready) rdy_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] ev_dat(input int i);
      if (i < ev_q.size()) return ev_q[i].dat;
      return {128{1'bx}};
   endfunction

   function automatic logic [127:0] ev_st(input int i);
      if (i < ev_q.size()) return 128'(ev_q[i].is_start);
      return {128{1'bx}};
   endfunction

   function automatic int ev_cyc(input int i);
      if (i < ev_q.size()) return ev_q[i].cyc;
      return -1000;
   endfunction

   task automatic clr_mon();
      ev_q.delete();
      acc_q.delete();
      rdy_cnt = 0;
   endtask

   task automatic start_msg(input logic [64:0] len, output int s_edge);
      msg_len   = len;
      msg_start = 1'b1;
      step();
      s_edge    = cyc;
      msg_start = 1'b0;
   endtask

   task automatic drive(input int n, input int gap_at, input int gap_len);
      for (int i = 0; i < n; i++) begin
         int waited;
         if (i == gap_at) begin
            valid = 1'b0;
            repeat (gap_len) step();
         end
         valid  = 1'b1;
         data   = wd[i];
         waited = 0;
         forever begin
            @(negedge clk);
            if (ready) break;
            waited++;
            if (waited > 2000) break;
         end
         if (waited > 2000) begin
            total++;
            bad++;
            $display("FAIL drive_timeout: word %0d never accepted", i);
            valid = 1'b0;
            return;
         end
         step();
      end
      valid = 1'b0;
   endtask

   task automatic wait_ev(input int n);
      for (int k = 0; k < 1000; k++) begin
         if (ev_q.size() >= n) return;
         step();
      end
      total++;
      bad++;
      $display("FAIL wait_ev_timeout: got %0d events want %0d", ev_q.size(), n);
   endtask

   task automatic req();
      step();
      rqst = 1'b1;
      step();
      rqst = 1'b0;
   endtask

   task automatic finish_msg(input string nm);
      repeat (3) step();
      chk({nm, "_busy_before_done"}, 128'(busy), 128'd1);
      tag_done = 1'b1;
      step();
      tag_done = 1'b0;
      chk({nm, "_busy_after_done"}, 128'(busy), 128'd0);
      step();
   endtask

   task automatic run_msg(input logic [64:0] len, input int nw, input int nblk,
                          input int gap_at, input int gap_len);
      int s_edge;
      clr_mon();
      start_msg(len, s_edge);
      fork
         drive(nw, gap_at, gap_len);
         begin
            wait_ev(1);
            for (int b = 1; b < nblk; b++) begin
               req();
               wait_ev(b + 1);
            end
         end
      join
   endtask

   initial begin
      int s_edge;

      tbl[0] = '{len: 65'd20, nwrd: 5,  fill: 32'hFFFF_FFFF, nblk: 2,
                 first: {4{32'hFFFF_FFFF}}, last: 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF};
      tbl[1] = '{len: 65'd18, nwrd: 5,  fill: 32'hFFFF_FFFF, nblk: 2,
                 first: {4{32'hFFFF_FFFF}}, last: 128'h0000_0000_0000_0000_0000_0000_0000_FFFF};
      tbl[2] = '{len: 65'd17, nwrd: 5,  fill: 32'hFFFF_FFFF, nblk: 2,
                 first: {4{32'hFFFF_FFFF}}, last: 128'h0000_0000_0000_0000_0000_0000_0000_00FF};
      tbl[3] = '{len: 65'd31, nwrd: 8,  fill: 32'h1122_3344, nblk: 2,
                 first: {4{32'h1122_3344}}, last: 128'h0022_3344_1122_3344_1122_3344_1122_3344};
      tbl[4] = '{len: 65'd5,  nwrd: 2,  fill: 32'hDEAD_BEEF, nblk: 1,
                 first: 128'h0000_0000_0000_0000_0000_00EF_DEAD_BEEF,
                 last:  128'h0000_0000_0000_0000_0000_00EF_DEAD_BEEF};
      tbl[5] = '{len: 65'd48, nwrd: 12, fill: 32'h5A5A_5A5A, nblk: 3,
                 first: {4{32'h5A5A_5A5A}}, last: {4{32'h5A5A_5A5A}}};

      // Reset state
      repeat (3) step();
      chk("rst_busy",  128'(busy),    128'd0);
      chk("rst_start", 128'(start),   128'd0);
      chk("rst_en",    128'(en_msg),  128'd0);
      chk("rst_msg",   msg,           128'd0);
      chk("rst_len",   128'(len_msg), 128'd0);
      chk("rst_ready", 128'(ready),   128'd0);
      chk("rst_err",   128'(err),     128'd0);
      rstn = 1'b1;
      step();

      // Basic two-block message with distinct words
      for (int i = 0; i < 8; i++) wd[i] = 32'hA000_0000 | i;
      run_msg(65'd32, 8, 2, -1, 0);
      chk("t1_nev",    128'(ev_q.size()), 128'd2);
      chk("t1_ev0_st", ev_st(0), 128'd1);
      chk("t1_blk0",   ev_dat(0), 128'hA000_0003_A000_0002_A000_0001_A000_0000);
      chk("t1_ev1_st", ev_st(1), 128'd0);
      chk("t1_blk1",   ev_dat(1), 128'hA000_0007_A000_0006_A000_0005_A000_0004);
      chk("t1_len",    128'(len_msg), 128'd32);
      finish_msg("t1");

      // Vector table: lengths and final-word masking
      for (int r = 0; r < 6; r++) begin
         string nm;
         nm = $sformatf("vec%0d", r);
         for (int i = 0; i < tbl[r].nwrd; i++) wd[i] = tbl[r].fill;
         run_msg(tbl[r].len, tbl[r].nwrd, tbl[r].nblk, -1, 0);
         chk({nm, "_nev"},   128'(ev_q.size()), 128'(tbl[r].nblk));
         chk({nm, "_st"},    ev_st(0), 128'd1);
         chk({nm, "_first"}, ev_dat(0), tbl[r].first);
         chk({nm, "_last"},  ev_dat(tbl[r].nblk - 1), tbl[r].last);
         chk({nm, "_len"},   len_msg, tbl[r].len);
         finish_msg(nm);
      end

      // Zero length: single zero block, start two edges after the start sample
      clr_mon();
      start_msg(65'd0, s_edge);
      wait_ev(1);
      chk("t4_lat",  128'(ev_cyc(0) - s_edge), 128'd2);
      chk("t4_st",   ev_st(0), 128'd1);
      chk("t4_blk",  ev_dat(0), 128'd0);
      repeat (5) step();
      chk("t4_nrdy", 128'(rdy_cnt), 128'd0);
      chk("t4_nev",  128'(ev_q.size()), 128'd1);
      finish_msg("t4");

      // FIFO-full stall with requests withheld, then in-order drain
      for (int i = 0; i < 24; i++) wd[i] = 32'hB000_0000 | i;
      clr_mon();
      start_msg(65'd96, s_edge);
      fork
         drive(24, -1, 0);
         begin
            wait_ev(1);
            repeat (40) step();
            chk("t5_stall_acc",   128'(acc_q.size()), 128'd23);
            chk("t5_stall_ready", 128'(ready), 128'd0);
            chk("t5_stall_nev",   128'(ev_q.size()), 128'd1);
            for (int b = 1; b < 6; b++) begin
               req();
               wait_ev(b + 1);
            end
         end
      join
      chk("t5_nev", 128'(ev_q.size()), 128'd6);
      chk("t5_acc", 128'(acc_q.size()), 128'd24);
      for (int b = 0; b < 6; b++) begin
         logic [127:0] exp;
         exp = {wd[4*b+3], wd[4*b+2], wd[4*b+1], wd[4*b]};
         chk($sformatf("t5_blk%0d", b), ev_dat(b), exp);
      end
      finish_msg("t5");

      // Request pending before the second block exists
      for (int i = 0; i < 8; i++) wd[i] = 32'hC000_0000 | i;
      run_msg(65'd32, 8, 2, 4, 10);
      chk("t6_nev",  128'(ev_q.size()), 128'd2);
      chk("t6_lat",  128'(ev_cyc(1) - ((acc_q.size() > 7) ? acc_q[7] : -1000)), 128'd1);
      chk("t6_blk1", ev_dat(1), 128'hC000_0007_C000_0006_C000_0005_C000_0004);
      finish_msg("t6");

      // Reset asserted mid-SERVE clears outputs immediately
      clr_mon();
      start_msg(65'd32, s_edge);
      drive(8, -1, 0);
      wait_ev(1);
      repeat (3) step();
      chk("t7_pre_msg", ev_dat(0), 128'hC000_0003_C000_0002_C000_0001_C000_0000);
      rstn = 1'b0;
      #1;
      chk("t7_busy",  128'(busy),    128'd0);
      chk("t7_msg",   msg,           128'd0);
      chk("t7_len",   128'(len_msg), 128'd0);
      chk("t7_start", 128'(start),   128'd0);
      chk("t7_en",    128'(en_msg),  128'd0);
      chk("t7_ready", 128'(ready),   128'd0);
      chk("t7_err",   128'(err),     128'd0);
      step();
      rstn = 1'b1;
      step();

      // Request in IDLE: ignored, flagged only when the checker is built
      clr_mon();
      rqst = 1'b1;
      step();
      rqst = 1'b0;
      step();
      chk("t8_nev",  128'(ev_q.size()), 128'd0);
      chk("t8_busy", 128'(busy), 128'd0);
`ifdef P_FEED_PROTO_CHK_EN
      chk("t8_err", 128'(err), 128'd1);
`else
      chk("t8_err", 128'(err), 128'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
